// File: rtl/logic_result_fifo.sv
// logic_result_fifo: registered result-word FIFO with a saturating nonzero-pop counter.
// Defining RESULT_FIFO_PARITY_EN adds out_parity, a stored even-parity bit per word.
module logic_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ena,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         nz_cnt
`ifdef RESULT_FIFO_PARITY_EN
   ,
   output logic                     out_parity
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CNT_W-1:0] nz_q, nz_d;
   logic push, pop;
   always_comb begin
      in_ready  = (level_q < FULL) && ena;
      out_valid = level_q != '0;
      out_data  = out_valid ? mem_q[rptr_q] : 8'h00;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready && ena;
      wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
      level_d   = (push && !pop) ? level_q + LW'(1) : (pop && !push) ? level_q - LW'(1) : level_q;
      nz_d      = (pop && out_data != 8'h00 && nz_q != '1) ? nz_q + CNT_W'(1) : nz_q;
      level     = level_q;
      nz_cnt    = nz_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         nz_q    <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         nz_q    <= nz_d;
      end
   end
   // Storage is left unreset; a reset only has to empty the pointers.
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wptr_q] <= in_data;
   end
`ifdef RESULT_FIFO_PARITY_EN
   logic par_q [DEPTH];
   always_ff @(posedge clk) begin
      if (push && !reset) par_q[wptr_q] <= ^in_data;
   end
   assign out_parity = out_valid ? par_q[rptr_q] : 1'b0;
`endif
endmodule
